// File: rtl/pipeline_ctrl_sequencer_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, hazard
// priority encoding and default sizing.
package pipe_ctrl_pkg;

  localparam int MDU_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 7;
  localparam int PERF_W_DEF      = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  // Numeric order matches priority: higher value wins.
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_MDU      = 2'd2,
    HZ_BRANCH   = 2'd3
  } hazard_e;

  function automatic hazard_e resolve_hazard(input logic branch,
                                             input logic mdu_stall,
                                             input logic load_use);
    hazard_e hz;
    if (branch) begin
      hz = HZ_BRANCH;
    end else if (mdu_stall) begin
      hz = HZ_MDU;
    end else if (load_use) begin
      hz = HZ_LOAD_USE;
    end else begin
      hz = HZ_NONE;
    end
    return hz;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sequencer_mdu_wait_timer.sv
// MDU wait supervision: saturating wait counter, terminal-count compare and
// the sticky timeout flag.
module mdu_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  input  logic timeout_set_i,
  output logic term_cnt_o,
  output logic mdu_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  // Counter runs only while the FSM stays in the wait state, else it clears.
  always_comb begin
    wait_cnt_d = {CNT_W{1'b0}};
    if (count_en_i) begin
      if (wait_cnt_q != CNT_MAX) begin
        wait_cnt_d = wait_cnt_q + CNT_ONE;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Sticky timeout: only reset clears it.
  always_comb begin
    timeout_d = timeout_q | timeout_set_i;
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= {CNT_W{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign term_cnt_o    = (wait_cnt_q >= CNT_TERM);
  assign mdu_timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline with an MDU-wait FSM.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W      = PERF_W_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic branch_taken,
  input  logic load_use_hazard,
  input  logic mdu_start,
  input  logic mdu_done,
  output logic pc_write,
  output logic IF_ID_write,
  output logic ID_EX_write,
  output logic IF_ID_flush,
  output logic ID_EX_flush,
  output logic EX_MEM_flush,
  output logic pc_src_branch,
  output logic mdu_abort,
  output logic mdu_timeout,
  output logic state_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] flush_count,
  output logic [PERF_W-1:0] stall_count
`endif
);

  state_e  state_q, state_d;
  hazard_e hz_s;
  logic    abort_q, abort_d;
  logic    in_wait_s, mdu_req_s, mdu_stall_s;
  logic    term_cnt_s, timeout_fire_s, count_en_s;

  assign in_wait_s = (state_q == MDU_WAIT);
  assign mdu_req_s = mdu_start & ~mdu_done;
  // Terminal count releases the stall in the same cycle it is reached.
  assign timeout_fire_s = in_wait_s & ~branch_taken & ~mdu_done & term_cnt_s;
  assign mdu_stall_s    = (~in_wait_s & mdu_req_s) |
                          (in_wait_s & ~mdu_done & ~term_cnt_s);
  assign hz_s           = resolve_hazard(branch_taken, mdu_stall_s, load_use_hazard);
  assign count_en_s     = in_wait_s & (state_d == MDU_WAIT);

  mdu_wait_timer #(
    .MDU_TIMEOUT (MDU_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .count_en_i    (count_en_s),
    .timeout_set_i (timeout_fire_s),
    .term_cnt_o    (term_cnt_s),
    .mdu_timeout_o (mdu_timeout)
  );

  // FSM next state: a branch always returns to RUN and drops any MDU wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          state_d = RUN;
        end else if (mdu_req_s) begin
          state_d = MDU_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MDU_WAIT: begin
        if (branch_taken || mdu_done || term_cnt_s) begin
          state_d = RUN;
        end else begin
          state_d = MDU_WAIT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Abort the MDU when a branch kills its op or the wait times out.
  always_comb begin
    abort_d = (branch_taken & (in_wait_s | mdu_req_s)) | timeout_fire_s;
  end

  // State and abort-pulse registers; reset never produces an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Per-stage enables and flushes decoded from the winning hazard.
  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_flush  = 1'b0;
    pc_src_branch = 1'b0;
    case (hz_s)
      HZ_BRANCH: begin
        IF_ID_flush   = 1'b1;
        ID_EX_flush   = 1'b1;
        EX_MEM_flush  = 1'b1;
        pc_src_branch = 1'b1;
      end
      HZ_MDU: begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_flush = 1'b1;
      end
      HZ_LOAD_USE: begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

  assign mdu_abort  = abort_q;
  assign state_busy = in_wait_s;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (branch_taken && (flush_cnt_q != PERF_MAX)) begin
      flush_cnt_d = flush_cnt_q + PERF_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (!pc_write && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_q <= {PERF_W{1'b0}};
      stall_cnt_q <= {PERF_W{1'b0}};
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_count = flush_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Directed bench for pipeline_ctrl_sequencer with a short MDU timeout (8).
module tb_pipeline_ctrl_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic branch_taken = 1'b0;
  logic load_use_hazard = 1'b0;
  logic mdu_start = 1'b0;
  logic mdu_done = 1'b0;
  logic pc_write, IF_ID_write, ID_EX_write;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic pc_src_branch, mdu_abort, mdu_timeout, state_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] flush_count, stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // {pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush,
  //  EX_MEM_flush, pc_src_branch, mdu_abort, mdu_timeout, state_busy}
  logic [9:0] obs;
  assign obs = {pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush,
                EX_MEM_flush, pc_src_branch, mdu_abort, mdu_timeout, state_busy};

  localparam logic [9:0] DEF      = 10'b1110000000;
  localparam logic [9:0] LDUSE    = 10'b0010100000;
  localparam logic [9:0] STALL_R  = 10'b0000010000;
  localparam logic [9:0] STALL_W  = 10'b0000010001;
  localparam logic [9:0] REL_W    = 10'b1110000001;
  localparam logic [9:0] BR_R     = 10'b1111111000;
  localparam logic [9:0] BR_W     = 10'b1111111001;
  localparam logic [9:0] ABORT    = 10'b1110000100;

  pipeline_ctrl_sequencer #(.MDU_TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_taken    (branch_taken),
    .load_use_hazard (load_use_hazard),
    .mdu_start       (mdu_start),
    .mdu_done        (mdu_done),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .ID_EX_write     (ID_EX_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_flush    (EX_MEM_flush),
    .pc_src_branch   (pc_src_branch),
    .mdu_abort       (mdu_abort),
    .mdu_timeout     (mdu_timeout),
    .state_busy      (state_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .flush_count     (flush_count),
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance to the next cycle, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic b, input logic lu, input logic st, input logic dn);
    @(posedge clk);
    #2;
    branch_taken    = b;
    load_use_hazard = lu;
    mdu_start       = st;
    mdu_done        = dn;
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("reset_idle0", DEF);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_idle", DEF);
    end

    cyc(1'b0, 1'b1, 1'b0, 1'b0); chk("load_use", LDUSE);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("load_use_after", DEF);

    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("mdu_c1", STALL_R);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("mdu_c2", STALL_W);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("mdu_c3", STALL_W);
    cyc(1'b0, 1'b0, 1'b1, 1'b1); chk("mdu_c4_done", REL_W);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("mdu_c5_idle", DEF);

    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("br_wait_enter", STALL_R);
    cyc(1'b1, 1'b0, 1'b1, 1'b0); chk("br_in_wait", BR_W);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("br_abort_pulse", ABORT);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("br_abort_gone", DEF);

    cyc(1'b0, 1'b1, 1'b1, 1'b0); chk("mdu_over_lduse", STALL_R);
    cyc(1'b0, 1'b0, 1'b1, 1'b1); chk("mdu_over_lduse_rel", REL_W);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("mdu_over_lduse_idle", DEF);

    cyc(1'b1, 1'b1, 1'b1, 1'b0); chk("br_over_all", BR_R);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("br_over_all_abort", ABORT);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("br_over_all_idle", DEF);

    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("to_enter", STALL_R);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_wait", STALL_W);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("to_release", REL_W);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("to_abort", 10'b1110000110);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("to_sticky1", 10'b1110000010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("to_sticky2", 10'b1110000010);

    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("rst_wait_enter", 10'b0000010010);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("rst_wait_busy", 10'b0000010011);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_mid_wait", DEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("rst_no_abort", DEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
